compute_nb_cid_3d_pipe: RTL and testbench



---
 rtl/MD_pkg.sv | 19 +
 rtl/compute_nb_cid_3d_pipe_axis_classify.sv | 29 ++
 rtl/compute_nb_cid_3d_pipe.sv | 152 +++++++++++++++
 tb/tb_compute_nb_cid_3d_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared molecular-dynamics definitions: cell-coordinate widths and
// relative neighbour-cell codes used by the neighbour-ID pipeline.
package MD_pkg;

  localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
  localparam int unsigned NUM_CELL_FOLDS       = 1;
  localparam int unsigned CELL_ID_WIDTH        = 2;

  typedef logic [CELL_ID_WIDTH-1:0] nb_cid_t;

  localparam nb_cid_t NB_CID_NONE  = 2'b00;
  localparam nb_cid_t NB_CID_MINUS = 2'b01;
  localparam nb_cid_t NB_CID_HOME  = 2'b10;
  localparam nb_cid_t NB_CID_PLUS  = 2'b11;

  // Per-axis codes packed {z, y, x}
  typedef nb_cid_t [2:0] nb_cid_3d_t;

endpackage

// File: rtl/compute_nb_cid_3d_pipe_axis_classify.sv
// Combinational per-axis classifier: turns the wrapped distance from the
// home cell into a minus/home/plus/none code and flags out-of-range inputs.
module nb_cid_axis_classify
  import MD_pkg::*;
#(
  parameter int unsigned GCELL_W = GLOBAL_CELL_ID_WIDTH,
  parameter int unsigned DIM     = 4
) (
  input  logic [GCELL_W-1:0]       src,
  input  logic [GCELL_W-1:0]       home,
  input  logic [GCELL_W:0]         d,
  output logic [CELL_ID_WIDTH-1:0] code_c,
  output logic                     range_err_c
);

  localparam logic [GCELL_W:0] D_ONE  = (GCELL_W+1)'(1);
  localparam logic [GCELL_W:0] D_LAST = (GCELL_W+1)'(DIM - 1);

  // Priority home > plus > minus, so DIM==1 is always home and DIM==2 prefers plus
  always_comb begin
    code_c      = NB_CID_NONE;
    range_err_c = (32'(src) >= DIM) || (32'(home) >= DIM);
    if (range_err_c)         code_c = NB_CID_NONE;
    else if (d == '0)        code_c = NB_CID_HOME;
    else if (d == D_ONE)     code_c = NB_CID_PLUS;
    else if (d == D_LAST)    code_c = NB_CID_MINUS;
  end

endmodule

// File: rtl/compute_nb_cid_3d_pipe.sv
// Two-stage valid/ready pipeline mapping a source particle's global 3D cell
// coordinate to per-axis relative neighbour codes around a selectable home
// cell (fold), with wrap-around and non-neighbour flagging.
// Optional statistics counter o_non_nb_cnt: define COMPUTE_NB_CID_STATS_EN.
module compute_nb_cid_3d_pipe
  import MD_pkg::*;
#(
  parameter int unsigned GCELL_W   = GLOBAL_CELL_ID_WIDTH,
  parameter int unsigned NUM_FOLDS = NUM_CELL_FOLDS,
  parameter int unsigned FOLD_W    = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  parameter int unsigned DIM_X     = 4,
  parameter int unsigned DIM_Y     = 4,
  parameter int unsigned DIM_Z     = 4,
  parameter logic [NUM_FOLDS-1:0][2:0][GCELL_W-1:0] HOME_GCID = '0,
  parameter int unsigned TAG_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [3*GCELL_W-1:0]       i_source_gcid,
  input  logic [FOLD_W-1:0]          i_fold_id,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [3*CELL_ID_WIDTH-1:0] o_nb_cid,
  output logic [TAG_W-1:0]           o_tag,
  output logic                       o_non_nb,
  output logic                       o_err_sticky
`ifdef COMPUTE_NB_CID_STATS_EN
  ,
  output logic [15:0]                o_non_nb_cnt
`endif
);

  localparam logic [2:0][31:0] DIM_V = {32'(DIM_Z), 32'(DIM_Y), 32'(DIM_X)};

  logic adv1_c, adv2_c;
  logic fold_ok_c;
  logic [2:0][GCELL_W-1:0] src_c, home_c;
  logic [2:0][GCELL_W:0]   d_c;

  logic                    v1;
  logic [2:0][GCELL_W-1:0] s1_src, s1_home;
  logic [2:0][GCELL_W:0]   s1_d;
  logic                    s1_fold_err;
  logic [TAG_W-1:0]        s1_tag;

  nb_cid_3d_t cls_code_c, nb_next_c;
  logic [2:0] cls_rerr_c;
  logic       non_nb_next_c, err_next_c;

  // Stage advance: a stage may load when it is empty or its contents move on
  assign adv2_c  = !o_valid || i_ready;
  assign adv1_c  = !v1 || adv2_c;
  assign o_ready = adv1_c;
  assign src_c   = i_source_gcid;

  // Home-cell select; an illegal fold falls back to fold 0
  always_comb begin
    fold_ok_c = (32'(i_fold_id) < NUM_FOLDS);
    home_c    = HOME_GCID[0];
    for (int unsigned f = 1; f < NUM_FOLDS; f++) begin
      if (fold_ok_c && (32'(i_fold_id) == f)) home_c = HOME_GCID[FOLD_W'(f)];
    end
  end

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic [GCELL_W:0] d_a;

    // Wrapped distance (src - home) mod DIM, one bit wider to hold src + DIM
    always_comb begin
      if (src_c[a] >= home_c[a]) d_a = {1'b0, src_c[a]} - {1'b0, home_c[a]};
      else d_a = {1'b0, src_c[a]} + (GCELL_W+1)'(DIM_V[a]) - {1'b0, home_c[a]};
    end
    assign d_c[a] = d_a;

    nb_cid_axis_classify #(
      .GCELL_W (GCELL_W),
      .DIM     (DIM_V[a])
    ) u_cls (
      .src         (s1_src[a]),
      .home        (s1_home[a]),
      .d           (s1_d[a]),
      .code_c      (cls_code_c[a]),
      .range_err_c (cls_rerr_c[a])
    );
  end

  // Final codes: illegal fold forces every axis to none
  always_comb begin
    nb_next_c     = cls_code_c;
    non_nb_next_c = 1'b0;
    err_next_c    = s1_fold_err || (|cls_rerr_c);
    if (s1_fold_err) nb_next_c = {NB_CID_NONE, NB_CID_NONE, NB_CID_NONE};
    for (int a = 0; a < 3; a++) begin
      if (nb_next_c[a] == NB_CID_NONE) non_nb_next_c = 1'b1;
    end
  end

  // Stage 1: capture request, selected home and wrapped distance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      s1_src      <= '0;
      s1_home     <= '0;
      s1_d        <= '0;
      s1_fold_err <= 1'b0;
      s1_tag      <= '0;
    end else if (adv1_c) begin
      v1 <= i_valid;
      if (i_valid) begin
        s1_src      <= src_c;
        s1_home     <= home_c;
        s1_d        <= d_c;
        s1_fold_err <= !fold_ok_c;
        s1_tag      <= i_tag;
      end
    end
  end

  // Stage 2: registered result, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_nb_cid     <= '0;
      o_tag        <= '0;
      o_non_nb     <= 1'b0;
      o_err_sticky <= 1'b0;
    end else if (adv2_c) begin
      o_valid <= v1;
      if (v1) begin
        o_nb_cid <= nb_next_c;
        o_tag    <= s1_tag;
        o_non_nb <= non_nb_next_c;
        if (err_next_c) o_err_sticky <= 1'b1;
      end
    end
  end

`ifdef COMPUTE_NB_CID_STATS_EN
  // Saturating count of delivered non-neighbour results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_non_nb_cnt <= '0;
    end else if (o_valid && i_ready && o_non_nb && (o_non_nb_cnt != 16'hFFFF)) begin
      o_non_nb_cnt <= o_non_nb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compute_nb_cid_3d_pipe.sv
// Bench for compute_nb_cid_3d_pipe: directed table, stall stream, random
// traffic against a reference model, mid-flight reset, and a small-DIM instance.
`timescale 1ns/1ps
module tb_compute_nb_cid_3d_pipe;

  localparam int unsigned GW = 3;
  localparam logic [2:0][2:0][GW-1:0] HOME_A = {{3'd3, 3'd2, 3'd1}, {3'd3, 3'd3, 3'd3}, {3'd0, 3'd0, 3'd0}};
  localparam logic [0:0][2:0][GW-1:0] HOME_B = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4x4x4 grid, 3 folds
  logic            a_valid, a_ready, a_ovalid, a_iready, a_nn, a_err;
  logic [3*GW-1:0] a_src;
  logic [1:0]      a_fold;
  logic [7:0]      a_tag, a_otag;
  logic [5:0]      a_nb;
  logic [15:0]     a_cnt;
  // Instance B: DIM_X=2, DIM_Y=4, DIM_Z=1, single fold
  logic            b_valid, b_ready, b_ovalid, b_iready, b_nn, b_err;
  logic [3*GW-1:0] b_src;
  logic            b_fold;
  logic [7:0]      b_tag, b_otag;
  logic [5:0]      b_nb;
  logic [15:0]     b_cnt;

  compute_nb_cid_3d_pipe #(
    .GCELL_W(GW), .NUM_FOLDS(3), .DIM_X(4), .DIM_Y(4), .DIM_Z(4), .HOME_GCID(HOME_A), .TAG_W(8)
  ) u_dut_a (
    .clk(clk), .rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_source_gcid(a_src),
    .i_fold_id(a_fold), .i_tag(a_tag), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_nb_cid(a_nb), .o_tag(a_otag), .o_non_nb(a_nn), .o_err_sticky(a_err)
`ifdef COMPUTE_NB_CID_STATS_EN
    , .o_non_nb_cnt(a_cnt)
`endif
  );

  compute_nb_cid_3d_pipe #(
    .GCELL_W(GW), .NUM_FOLDS(1), .DIM_X(2), .DIM_Y(4), .DIM_Z(1), .HOME_GCID(HOME_B), .TAG_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_source_gcid(b_src),
    .i_fold_id(b_fold), .i_tag(b_tag), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_nb_cid(b_nb), .o_tag(b_otag), .o_non_nb(b_nn), .o_err_sticky(b_err)
`ifdef COMPUTE_NB_CID_STATS_EN
    , .o_non_nb_cnt(b_cnt)
`endif
  );

`ifndef COMPUTE_NB_CID_STATS_EN
  assign a_cnt = '0;
  assign b_cnt = '0;
`endif

  typedef struct {
    logic [5:0] nb;
    logic       nn;
    logic       err;
    logic [7:0] tag;
    int         t_push;
    bit         lat;
  } item_t;

  typedef struct {
    int         sx, sy, sz, fold;
    logic [5:0] nb;
    logic       nn;
    logic       err;
  } vec_t;

  int    vecs = 0;
  int    errs = 0;
  int    cyc  = 0;
  item_t q[$];
  item_t drv_item;
  bit    lat_en = 0;
  bit    exp_sticky = 0;
  int    exp_cnt = 0;
  bit    ready_low_seen = 0;
  bit    held = 0;
  logic [5:0] h_nb;
  logic [7:0] h_tag;
  logic       h_nn;
  int home_a[3][3] = '{'{0, 0, 0}, '{3, 3, 3}, '{1, 2, 3}};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model for instance A: plain modular arithmetic on integers
  function automatic item_t model_a(input int sx, input int sy, input int sz, input int fold,
                                    input logic [7:0] tag);
    item_t r;
    int s[3];
    int d, code, f;
    bit bad;
    r.nb = '0; r.nn = 1'b0; r.err = 1'b0; r.tag = tag; r.t_push = 0; r.lat = 1'b0;
    s[0] = sx; s[1] = sy; s[2] = sz;
    bad = (fold >= 3);
    f   = bad ? 0 : fold;
    for (int a = 0; a < 3; a++) begin
      code = 0;
      if (s[a] >= 4) r.err = 1'b1;
      else if (!bad) begin
        d = (s[a] - home_a[f][a] + 4) % 4;
        if (d == 0) code = 2;
        else if (d == 1) code = 3;
        else if (d == 3) code = 1;
      end
      r.nb[2*a +: 2] = 2'(code);
      if (code == 0) r.nn = 1'b1;
    end
    if (bad) r.err = 1'b1;
    return r;
  endfunction

  // Scoreboard / protocol monitor for instance A, sampled mid-cycle
  initial begin : mon
    item_t it;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete(); exp_sticky = 0; exp_cnt = 0; held = 0;
        continue;
      end
      if (held) begin
        chk("hold_valid", 32'(a_ovalid), 32'd1);
        chk("hold_nb", 32'(a_nb), 32'(h_nb));
        chk("hold_tag", 32'(a_otag), 32'(h_tag));
        chk("hold_non_nb", 32'(a_nn), 32'(h_nn));
      end
      held = a_ovalid && !a_iready;
      h_nb = a_nb; h_tag = a_otag; h_nn = a_nn;
      chk("o_ready", 32'(a_ready), 32'(!((q.size() == 2) && !a_iready)));
      if (a_valid && !a_ready) ready_low_seen = 1;
      if (a_ovalid && a_iready) begin
        if (q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_output: got tag %0h expected no result (t=%0t)", a_otag, $time);
        end else begin
          it = q.pop_front();
          if (it.err) exp_sticky = 1;
          chk("nb_cid", 32'(a_nb), 32'(it.nb));
          chk("non_nb", 32'(a_nn), 32'(it.nn));
          chk("tag", 32'(a_otag), 32'(it.tag));
          chk("err_sticky", 32'(a_err), 32'(exp_sticky));
          if (it.lat) chk("latency", 32'(cyc - it.t_push), 32'd2);
`ifdef COMPUTE_NB_CID_STATS_EN
          chk("non_nb_cnt", 32'(a_cnt), 32'(exp_cnt));
`endif
          if (it.nn && exp_cnt < 65535) exp_cnt++;
        end
      end
      if (a_valid && a_ready) begin
        it = drv_item;
        it.t_push = cyc;
        q.push_back(it);
      end
    end
  end

  task automatic a_set(input int sx, input int sy, input int sz, input int fold, input logic [7:0] tag);
    a_src  = {3'(sz), 3'(sy), 3'(sx)};
    a_fold = 2'(fold);
    a_tag  = tag;
  endtask

  // Hold a request until accepted (bounded), then step to the next cycle
  task automatic a_push(input item_t it);
    int k = 0;
    drv_item = it;
    a_valid  = 1'b1;
    do begin @(negedge clk); k++; end while (!a_ready && k < 50);
    if (!a_ready) begin
      vecs++; errs++;
      $display("FAIL accept_timeout: got o_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic a_drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin @(posedge clk); k++; end
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic b_one(input int sx, input int sy, input int sz, input int fold, input logic [7:0] tag,
                       input logic [5:0] nb, input logic nn, input logic err);
    int k = 0;
    b_src = {3'(sz), 3'(sy), 3'(sx)}; b_fold = 1'(fold); b_tag = tag; b_valid = 1'b1;
    @(negedge clk);
    chk("b_accept", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    do begin @(negedge clk); k++; end while (!b_ovalid && k < 6);
    chk("b_latency", 32'(k), 32'd2);
    chk("b_nb_cid", 32'(b_nb), 32'(nb));
    chk("b_non_nb", 32'(b_nn), 32'(nn));
    chk("b_tag", 32'(b_otag), 32'(tag));
    chk("b_err_sticky", 32'(b_err), 32'(err));
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];

  initial begin : main
    item_t it;
    int idx, c;
    tbl[0] = '{sx:3, sy:1, sz:0, fold:0, nb:6'b101101, nn:1'b0, err:1'b0};
    tbl[1] = '{sx:2, sy:0, sz:0, fold:0, nb:6'b101000, nn:1'b1, err:1'b0};
    tbl[2] = '{sx:0, sy:2, sz:3, fold:1, nb:6'b100111, nn:1'b0, err:1'b0};
    tbl[3] = '{sx:0, sy:2, sz:3, fold:0, nb:6'b010010, nn:1'b1, err:1'b0};
    tbl[4] = '{sx:0, sy:3, sz:0, fold:2, nb:6'b111101, nn:1'b0, err:1'b0};
    tbl[5] = '{sx:5, sy:1, sz:0, fold:0, nb:6'b101100, nn:1'b1, err:1'b1};
    tbl[6] = '{sx:1, sy:1, sz:1, fold:3, nb:6'b000000, nn:1'b1, err:1'b1};
    tbl[7] = '{sx:3, sy:3, sz:3, fold:1, nb:6'b101010, nn:1'b0, err:1'b0};

    a_valid = 0; a_iready = 1; a_src = '0; a_fold = '0; a_tag = '0;
    b_valid = 0; b_iready = 1; b_src = '0; b_fold = '0; b_tag = '0;
    drv_item = model_a(0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", 32'(a_ovalid), 32'd0);
    chk("rst_nb_cid", 32'(a_nb), 32'd0);
    chk("rst_tag", 32'(a_otag), 32'd0);
    chk("rst_non_nb", 32'(a_nn), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_b_valid", 32'(b_ovalid), 32'd0);
    rst = 0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(a_ready), 32'd1);

    // Directed table, back to back with no stall: latency is exactly 2
    lat_en = 1;
    for (int i = 0; i < 8; i++) begin
      a_set(tbl[i].sx, tbl[i].sy, tbl[i].sz, tbl[i].fold, 8'(8'h10 + i));
      it = '{nb:tbl[i].nb, nn:tbl[i].nn, err:tbl[i].err, tag:8'(8'h10 + i), t_push:0, lat:1'b1};
      a_push(it);
    end
    a_valid = 0;
    lat_en = 0;
    a_drain();

    // Ten-request stream with downstream stalled for cycles 3..6
    idx = 0; c = 0; ready_low_seen = 0;
    while (idx < 10 && c < 200) begin
      a_iready = !(c >= 3 && c <= 6);
      a_set(idx % 4, (idx + 1) % 4, (idx * 3) % 4, idx % 3, 8'(8'h40 + idx));
      drv_item = model_a(idx % 4, (idx + 1) % 4, (idx * 3) % 4, idx % 3, 8'(8'h40 + idx));
      a_valid = 1;
      @(negedge clk);
      if (a_ready) idx++;
      @(posedge clk); #1;
      c++;
    end
    a_valid = 0; a_iready = 1;
    chk("stream_sent", 32'(idx), 32'd10);
    chk("stream_ready_dropped", 32'(ready_low_seen), 32'd1);
    a_drain();

    // Random traffic and backpressure
    for (int r = 0; r < 400; r++) begin
      int sx, sy, sz, fd;
      logic [7:0] tg;
      sx = int'($urandom_range(0, 5)); sy = int'($urandom_range(0, 5));
      sz = int'($urandom_range(0, 5)); fd = int'($urandom_range(0, 3));
      tg = 8'($urandom);
      a_iready = ($urandom_range(0, 3) != 0);
      a_valid  = ($urandom_range(0, 1) != 0);
      a_set(sx, sy, sz, fd, tg);
      drv_item = model_a(sx, sy, sz, fd, tg);
      @(posedge clk); #1;
    end
    a_valid = 0; a_iready = 1;
    a_drain();

    // Reset with two requests in flight
    a_set(1, 1, 1, 0, 8'hA1);
    a_push(model_a(1, 1, 1, 0, 8'hA1));
    a_set(2, 2, 2, 0, 8'hA2);
    a_push(model_a(2, 2, 2, 0, 8'hA2));
    a_valid = 0;
    chk("pre_rst_valid", 32'(a_ovalid), 32'd1);
    rst = 1;
    #1;
    chk("rst_async_valid", 32'(a_ovalid), 32'd0);
    chk("rst_async_err", 32'(a_err), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("ready_after_midrst", 32'(a_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(a_ovalid), 32'd0);
    end
    @(posedge clk); #1;

`ifdef COMPUTE_NB_CID_STATS_EN
    for (int i = 0; i < 3; i++) begin
      a_set(2, 0, 0, 0, 8'(8'hC0 + i));
      a_push(model_a(2, 0, 0, 0, 8'(8'hC0 + i)));
    end
    a_valid = 0;
    a_drain();
    chk("cnt_three", 32'(a_cnt), 32'd3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("cnt_after_rst", 32'(a_cnt), 32'd0);
    @(posedge clk); #1;
`endif

    // Small-dimension instance: DIM 2 prefers plus, DIM 1 is always home
    b_one(1, 0, 0, 0, 8'hB0, 6'b101011, 1'b0, 1'b0);
    b_one(0, 3, 0, 0, 8'hB1, 6'b100110, 1'b0, 1'b0);
    b_one(2, 0, 0, 0, 8'hB2, 6'b101000, 1'b1, 1'b1);
    b_one(0, 0, 0, 1, 8'hB3, 6'b000000, 1'b1, 1'b1);
    b_one(1, 0, 1, 0, 8'hB4, 6'b001011, 1'b1, 1'b1);
    b_one(0, 0, 0, 0, 8'hB5, 6'b101010, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
